mult4_seq_ctrl: RTL and testbench
=================================

Name: mult4_seq_ctrl

Overview:
- Sequential 4x4 unsigned multiplier controller.
- Time-multiplexes one 2x2 multiplier core over the four partial products (ll, lh, hl, hh) and accumulates them into an 8-bit product.
- Trades the area of the four-instance combinational 4x4 multiplier for a 4-cycle latency.
- Uses a valid/ready handshake on both input and output.
- Sits between an operand source and a result sink in the scaled-multiplier evaluation flow.

Parameters:
- CNT_W, 16, width of the completed-operation counter op_count (minimum 1).

Ports:
- clk  input  1  single system clock, all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- in_a  input  4  multiplicand A.
- in_b  input  4  multiplier B.
- out_valid  output  1  product valid.
- out_ready  input  1  sink accepts product.
- out_p  output  8  product A*B.
- busy  output  1  high in any state other than IDLE.
- op_count  output  CNT_W  number of products handed off; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, step=0, acc=0, latched operands=0.
  - out_p=0, out_valid=0, in_ready=1, busy=0, op_count=0.
  - Reset mid-operation abandons the operation; no result is emitted and op_count is unchanged from 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a/in_b, acc<=0, step<=0, go to CALC.
- CALC:
  - in_ready=0.
  - The 2x2 core is driven combinationally from the latched operands, selected by step:
    - step 0: A[1:0]*B[1:0], shift 0.
    - step 1: A[1:0]*B[3:2], shift 2.
    - step 2: A[3:2]*B[1:0], shift 2.
    - step 3: A[3:2]*B[3:2], shift 4.
  - Each edge: acc <= acc + (pp << shift), with the 4-bit core output zero-extended to 8 bits. Overflow is impossible (max 225).
  - step increments; after step 3 the state goes to DONE and out_p<=final acc.
- DONE:
  - out_valid=1; out_p is held stable until handshake.
  - On out_ready: op_count<=op_count+1 (wraps), out_valid<=0, go to IDLE.
  - in_valid is ignored in DONE.
- Latency: acceptance edge E0; accumulations on E1..E4; out_valid visible after E4. Minimum 5 cycles per operation with out_ready held high.
- Input handshake stalls (in_ready=0) from the edge after acceptance until the cycle after output handoff.
- Simultaneous out_ready and a pending in_valid in DONE: only the output handshake happens. The input is taken next cycle in IDLE.
- out_ready asserted while out_valid=0 has no effect.
- in_a/in_b changes after acceptance do not affect the result.
- busy = (state != IDLE).

Optional Feature:
- Macro: MULT4_SEQ_EARLY_ZERO_EN.
- Defined:
  - On acceptance with in_a==0 or in_b==0, go directly IDLE->DONE with out_p<=0, skipping CALC (latency 1 edge).
  - op_count increments normally.
- Undefined:
  - Zero operands take the full 4-step path; result 0 after E4.

Decomposition:
- Package mult4_seq_pkg:
  - state enum (IDLE, CALC, DONE).
  - localparams for step count (4) and the shift table {0,2,2,4}.
  - operand-slice select constants.
- Sub-module mult2_core:
  - Combinational 2x2 unsigned multiplier, ports A[1:0], B[1:0], P[3:0].
  - Instantiated once and swappable for any learned 2x2 multiplier variant with the same port list.

Test Plan:
- Basic:
  - Stimulus: reset, then in_a=3, in_b=2, in_valid for 1 cycle, out_ready=1.
  - Response: out_valid rises after the 4th edge following acceptance; out_p=6; op_count=1; busy high E1..E4.
- Maximum operands:
  - Stimulus: in_a=15, in_b=15.
  - Response: out_p=225; each step's acc increments match the partial products 9, 9<<2, 9<<2, 9<<4.
- Back-pressure:
  - Stimulus: in_a=10, in_b=7, out_ready=0 for 6 cycles, new in_valid held meanwhile.
  - Response: out_p=70 stable; in_ready=0; second operand accepted only the cycle after out_ready handshake.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during step 2 of 12*5.
  - Response: all outputs return to reset values immediately; no out_valid; op_count=0.
- Zero operands:
  - Stimulus: in_a=0, in_b=9.
  - Response without macro: out_p=0 after 4 edges.
  - Response with MULT4_SEQ_EARLY_ZERO_EN: out_valid after 1 edge.
- Counter wrap:
  - Stimulus: CNT_W=2, 5 back-to-back operations.
  - Response: op_count sequence 1,2,3,0,1; exhaustive 256-pair sweep matches A*B.

Source files
------------

// File: rtl/mult4_seq_pkg.sv
// ============================================================================
// Module      : mult4_seq_pkg
// Description : Shared types and constants for the sequential 4x4 multiplier
//               controller. Holds the controller state encoding, the number
//               of partial-product steps, the per-step shift amounts and the
//               bit positions that choose the operand halves for each step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult4_seq_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Four partial products: ll, lh, hl, hh.
    localparam int unsigned C_NUM_STEPS = 4;
    localparam logic [1:0]  C_LAST_STEP = 2'(C_NUM_STEPS - 1);

    // Shift amounts for the partial products, indexed by step: {0, 2, 2, 4}.
    localparam logic [2:0] C_SHIFT_S0 = 3'd0;
    localparam logic [2:0] C_SHIFT_S1 = 3'd2;
    localparam logic [2:0] C_SHIFT_S2 = 3'd2;
    localparam logic [2:0] C_SHIFT_S3 = 3'd4;

    // Step bit that selects the upper half of A (steps 2,3) and of B (steps 1,3).
    localparam int unsigned C_A_SEL_BIT = 1;
    localparam int unsigned C_B_SEL_BIT = 0;

    // Shift applied to the partial product produced in a given step.
    function automatic logic [2:0] step_shift(input logic [1:0] step);
        logic [2:0] sh;
        case (step)
            2'd0:    sh = C_SHIFT_S0;
            2'd1:    sh = C_SHIFT_S1;
            2'd2:    sh = C_SHIFT_S2;
            default: sh = C_SHIFT_S3;
        endcase
        return sh;
    endfunction

    // Pick the low or high 2-bit slice of a 4-bit operand.
    function automatic logic [1:0] slice2(input logic [3:0] v, input logic hi);
        return hi ? v[3:2] : v[1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult2_core.sv
// ============================================================================
// Module      : mult2_core
// Description : Combinational 2x2 unsigned multiplier. Any 2x2 multiplier
//               variant with the same port list can be dropped in instead.
// Ports       : a [1:0] - multiplicand
//               b [1:0] - multiplier
//               p [3:0] - product a*b
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult2_core (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    assign p = {2'b00, a} * {2'b00, b};

endmodule

`default_nettype wire

// File: rtl/mult4_seq_ctrl.sv
// ============================================================================
// Module      : mult4_seq_ctrl
// Description : Sequential 4x4 unsigned multiplier. One 2x2 core is reused
//               over four steps; the shifted partial products accumulate into
//               an 8-bit product. Valid/ready handshake on input and output.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               in_valid/in_ready   - operand handshake
//               in_a, in_b [3:0]    - operands
//               out_valid/out_ready - product handshake
//               out_p [7:0]         - product, held stable until handoff
//               busy                - controller not in IDLE
//               op_count [CNT_W-1:0]- products handed off, wraps
// Options     : MULT4_SEQ_EARLY_ZERO_EN - a zero operand goes straight to DONE
//               with a zero product, skipping the four accumulation steps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult4_seq_ctrl
    import mult4_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_p,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_e           r_state_q, w_state_d;
    logic [1:0]       r_step_q, w_step_d;
    logic [7:0]       r_acc_q, w_acc_d;
    logic [3:0]       r_a_q, w_a_d;
    logic [3:0]       r_b_q, w_b_d;
    logic [7:0]       r_out_p_q, w_out_p_d;
    logic [CNT_W-1:0] r_op_count_q, w_op_count_d;

    logic [1:0] w_core_a;
    logic [1:0] w_core_b;
    logic [3:0] w_pp;
    logic [7:0] w_pp_shifted;

    // Operand halves chosen by the step counter, from the latched operands only.
    assign w_core_a = slice2(r_a_q, r_step_q[C_A_SEL_BIT]);
    assign w_core_b = slice2(r_b_q, r_step_q[C_B_SEL_BIT]);

    mult2_core u_core (
        .a (w_core_a),
        .b (w_core_b),
        .p (w_pp)
    );

    assign w_pp_shifted = {4'b0000, w_pp} << step_shift(r_step_q);

    always_comb begin
        w_state_d    = r_state_q;
        w_step_d     = r_step_q;
        w_acc_d      = r_acc_q;
        w_a_d        = r_a_q;
        w_b_d        = r_b_q;
        w_out_p_d    = r_out_p_q;
        w_op_count_d = r_op_count_q;

        case (r_state_q)
            ST_IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone accepts.
                if (in_valid) begin
                    w_a_d     = in_a;
                    w_b_d     = in_b;
                    w_acc_d   = 8'd0;
                    w_step_d  = 2'd0;
                    w_state_d = ST_CALC;
`ifdef MULT4_SEQ_EARLY_ZERO_EN
                    if ((in_a == 4'd0) || (in_b == 4'd0)) begin
                        w_out_p_d = 8'd0;
                        w_state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_CALC: begin
                w_acc_d  = r_acc_q + w_pp_shifted;
                w_step_d = r_step_q + 2'd1;
                if (r_step_q == C_LAST_STEP) begin
                    w_out_p_d = w_acc_d;
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Pending in_valid is ignored here; it is taken next cycle in IDLE.
                if (out_ready) begin
                    w_op_count_d = r_op_count_q + CNT_W'(1);
                    w_state_d    = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q    <= ST_IDLE;
            r_step_q     <= 2'd0;
            r_acc_q      <= 8'd0;
            r_a_q        <= 4'd0;
            r_b_q        <= 4'd0;
            r_out_p_q    <= 8'd0;
            r_op_count_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_step_q     <= w_step_d;
            r_acc_q      <= w_acc_d;
            r_a_q        <= w_a_d;
            r_b_q        <= w_b_d;
            r_out_p_q    <= w_out_p_d;
            r_op_count_q <= w_op_count_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = (r_state_q == ST_DONE);
    assign busy      = (r_state_q != ST_IDLE);
    assign out_p     = r_out_p_q;
    assign op_count  = r_op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mult4_seq_ctrl.sv
// ============================================================================
// Module      : tb_mult4_seq_ctrl
// Description : Self-checking bench for mult4_seq_ctrl. Products are queued
//               as operands are accepted and compared when the DUT hands off.
//               A 2-bit op_count exercises counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult4_seq_ctrl;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [3:0]       in_a = 4'd0;
    logic [3:0]       in_b = 4'd0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [7:0]       out_p;
    logic [CNT_W-1:0] op_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0]       exp_q[$];
    logic [CNT_W-1:0] exp_count = '0;

    mult4_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    check("sb_out_p", {24'd0, out_p}, {24'd0, exp_q[0]});
                    if (out_ready) begin
                        check("sb_op_count", {30'd0, op_count}, {30'd0, exp_count});
                        void'(exp_q.pop_front());
                        exp_count = exp_count + 1'b1;
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(8'(in_a) * 8'(in_b));
        end
    end

    // Present operands until accepted; returns #1 after the acceptance edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int t;
        t = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 4'($urandom);
        in_b = 4'($urandom);
    endtask

    // Count edges after acceptance until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("out_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [7:0] acc_exp [4];
        acc_exp = '{8'd9, 8'd45, 8'd81, 8'd225};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_p", {24'd0, out_p}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_op_count", {30'd0, op_count}, 32'd0);
        rst_n = 1'b1;

        // Basic 3*2
        out_ready = 1'b1;
        send(4'd3, 4'd2);
        check("basic_busy", {31'd0, busy}, 32'd1);
        check("basic_in_ready", {31'd0, in_ready}, 32'd0);
        wait_out(lat);
        check("basic_latency", lat, 32'd4);
        check("basic_out_p", {24'd0, out_p}, 32'd6);
        @(posedge clk); #1;
        check("basic_op_count", {30'd0, op_count}, 32'd1);
        check("basic_idle", {31'd0, busy}, 32'd0);

        // Maximum operands, step-by-step accumulation
        send(4'd15, 4'd15);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("max_acc_step", {24'd0, dut.r_acc_q}, {24'd0, acc_exp[k]});
        end
        check("max_out_valid", {31'd0, out_valid}, 32'd1);
        check("max_out_p", {24'd0, out_p}, 32'd225);
        @(posedge clk); #1;

        // Back-pressure with a pending second operand
        out_ready = 1'b0;
        send(4'd10, 4'd7);
        wait_out(lat);
        in_a = 4'd5;
        in_b = 4'd5;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_p", {24'd0, out_p}, 32'd70);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handoff_valid", {31'd0, out_valid}, 32'd0);
        check("bp_handoff_ready", {31'd0, in_ready}, 32'd1);
        check("bp_op_count_wrap0", {30'd0, op_count}, 32'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_accepted", {31'd0, busy}, 32'd1);
        wait_out(lat);
        check("bp_second_out_p", {24'd0, out_p}, 32'd25);
        @(posedge clk); #1;
        check("bp_op_count_wrap1", {30'd0, op_count}, 32'd0);

        // Reset during step 2 of 12*5
        send(4'd12, 4'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_count = '0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_out_p", {24'd0, out_p}, 32'd0);
        check("midrst_op_count", {30'd0, op_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_output", {31'd0, out_valid}, 32'd0);
        check("midrst_count_kept", {30'd0, op_count}, 32'd0);

        // Zero operand
        send(4'd0, 4'd9);
        wait_out(lat);
`ifdef MULT4_SEQ_EARLY_ZERO_EN
        check("zero_latency", lat, 32'd0);
`else
        check("zero_latency", lat, 32'd4);
`endif
        check("zero_out_p", {24'd0, out_p}, 32'd0);
        @(posedge clk); #1;
        check("zero_op_count", {30'd0, op_count}, 32'd1);

        // Five back-to-back operations: op_count 2,3,0,1,2
        for (int i = 0; i < 5; i++) begin
            send(4'($urandom), 4'($urandom));
            wait_out(lat);
            @(posedge clk); #1;
            check("b2b_op_count", {30'd0, op_count}, (i + 2) % 4);
        end

        // Exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                send(4'(a), 4'(b));
                wait_out(lat);
                check("sweep_out_p", {24'd0, out_p}, a * b);
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
